rocc_share_arbiter: RTL and testbench

- Shares one RoCC-style accelerator (accumulator-class custom unit) between NUM_REQ requesting cores.
- Round-robin arbitration grants one command at a time and registers it into a single-entry command buffer.
- Issues the command to the accelerator and, if a response is expected (xd), holds the grant until the response returns to the owning requester.
- Sits between per-core RoCC command/response ports and the accelerator's single cmd/resp port pair.

---
 rtl/rocc_share_pkg.sv | 23 ++
 rtl/rocc_share_arbiter_if.sv | 65 ++++++
 rtl/rocc_rr_arbiter.sv | 34 +++
 rtl/rocc_share_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rocc_share_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rocc_share_pkg.sv
// Shared types and widths for the RoCC share arbiter.
package rocc_share_pkg;

  localparam int unsigned FUNCT_W  = 7;
  localparam int unsigned RD_W     = 5;
  // Widest XLEN the command buffer can hold; narrower XLEN uses the low bits.
  localparam int unsigned MAX_XLEN = 64;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitResp
  } state_e;

  typedef struct packed {
    logic [FUNCT_W-1:0]  funct;
    logic [RD_W-1:0]     rd;
    logic                xd;
    logic [MAX_XLEN-1:0] rs1;
    logic [MAX_XLEN-1:0] rs2;
  } cmd_t;

endpackage

// File: rtl/rocc_share_arbiter_if.sv
// Bus bundle between NUM_REQ RoCC requesters, the share arbiter and one accelerator.
// The acc_timeout signal exists only when ROCC_SHARE_ARB_TIMEOUT_EN is defined.
interface rocc_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 64
);
  import rocc_share_pkg::*;

  // Requester side
  logic [NUM_REQ-1:0]         req_cmd_valid;
  logic [NUM_REQ-1:0]         req_cmd_ready;
  logic [FUNCT_W*NUM_REQ-1:0] req_cmd_funct;
  logic [RD_W*NUM_REQ-1:0]    req_cmd_rd;
  logic [NUM_REQ-1:0]         req_cmd_xd;
  logic [XLEN*NUM_REQ-1:0]    req_cmd_rs1;
  logic [XLEN*NUM_REQ-1:0]    req_cmd_rs2;
  logic [NUM_REQ-1:0]         req_resp_valid;
  logic [NUM_REQ-1:0]         req_resp_ready;
  logic [RD_W-1:0]            req_resp_rd;
  logic [XLEN-1:0]            req_resp_data;
  logic [NUM_REQ-1:0]         req_busy;

  // Accelerator side
  logic                       acc_cmd_valid;
  logic                       acc_cmd_ready;
  logic [FUNCT_W-1:0]         acc_cmd_funct;
  logic [RD_W-1:0]            acc_cmd_rd;
  logic                       acc_cmd_xd;
  logic [XLEN-1:0]            acc_cmd_rs1;
  logic [XLEN-1:0]            acc_cmd_rs2;
  logic                       acc_resp_valid;
  logic                       acc_resp_ready;
  logic [RD_W-1:0]            acc_resp_rd;
  logic [XLEN-1:0]            acc_resp_data;
`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
  logic                       acc_timeout;
`endif

  // Arbiter view
  modport slave (
    input  req_cmd_valid, req_cmd_funct, req_cmd_rd, req_cmd_xd, req_cmd_rs1, req_cmd_rs2,
    input  req_resp_ready,
    input  acc_cmd_ready, acc_resp_valid, acc_resp_rd, acc_resp_data,
    output req_cmd_ready, req_resp_valid, req_resp_rd, req_resp_data, req_busy,
    output acc_cmd_valid, acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2,
    output acc_resp_ready
`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
    , output acc_timeout
`endif
  );

  // Environment view: requesters plus accelerator
  modport master (
    output req_cmd_valid, req_cmd_funct, req_cmd_rd, req_cmd_xd, req_cmd_rs1, req_cmd_rs2,
    output req_resp_ready,
    output acc_cmd_ready, acc_resp_valid, acc_resp_rd, acc_resp_data,
    input  req_cmd_ready, req_resp_valid, req_resp_rd, req_resp_data, req_busy,
    input  acc_cmd_valid, acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2,
    input  acc_resp_ready
`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
    , input acc_timeout
`endif
  );

endinterface

// File: rtl/rocc_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_grant and wraps.
module rocc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // First requester found after last_grant wins; at most one bit is set.
  always_comb begin
    logic              found;
    int unsigned       idx;
    logic [IDX_W-1:0]  sel;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_grant) + off) % NUM_REQ;
      sel = IDX_W'(idx);
      if (enable && !found && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rocc_share_arbiter.sv
// Shares one RoCC accelerator between NUM_REQ cores. One command is in flight at a time;
// commands with xd=1 keep the grant until the response reaches the owning requester.
// Optional response watchdog: define ROCC_SHARE_ARB_TIMEOUT_EN.
module rocc_share_arbiter
  import rocc_share_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                 clock,
  input logic                 reset,
  rocc_share_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Elaboration-time parameter sanity
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (XLEN > MAX_XLEN || XLEN == 0) begin : g_bad_xlen
    $error("XLEN must be in 1..MAX_XLEN");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_e             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_grant_q;
  cmd_t               cmd_q;
  logic               acc_cmd_valid_q;
  logic [NUM_REQ-1:0] busy_q;

  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  cmd_t               cmd_sel;
  logic               resp_fire;

`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer_q;
  logic               timeout_q;
  logic               timer_expired;

  assign timer_expired   = (timer_q == TIMER_W'(TIMEOUT_CYCLES));
  assign bus.acc_timeout = timeout_q;
`endif

  // No acceptance while reset is held, even though the state already reads idle.
  assign arb_en = (state_q == StIdle) && reset;

  rocc_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req        (bus.req_cmd_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Select the winning requester's command fields.
  always_comb begin
    cmd_sel                = '0;
    cmd_sel.funct          = bus.req_cmd_funct[FUNCT_W*grant_idx +: FUNCT_W];
    cmd_sel.rd             = bus.req_cmd_rd[RD_W*grant_idx +: RD_W];
    cmd_sel.xd             = bus.req_cmd_xd[grant_idx];
    cmd_sel.rs1[XLEN-1:0]  = bus.req_cmd_rs1[XLEN*grant_idx +: XLEN];
    cmd_sel.rs2[XLEN-1:0]  = bus.req_cmd_rs2[XLEN*grant_idx +: XLEN];
  end

  assign bus.req_cmd_ready = grant;
  assign bus.req_busy      = busy_q;
  assign bus.acc_cmd_valid = acc_cmd_valid_q;
  assign bus.acc_cmd_funct = cmd_q.funct;
  assign bus.acc_cmd_rd    = cmd_q.rd;
  assign bus.acc_cmd_xd    = cmd_q.xd;
  assign bus.acc_cmd_rs1   = cmd_q.rs1[XLEN-1:0];
  assign bus.acc_cmd_rs2   = cmd_q.rs2[XLEN-1:0];

  // Response path: zero-latency pass-through to the owner, only while waiting for it.
  always_comb begin
    bus.req_resp_valid = '0;
    bus.req_resp_rd    = '0;
    bus.req_resp_data  = '0;
    bus.acc_resp_ready = 1'b0;
    if (state_q == StWaitResp) begin
`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
      if (timer_expired) begin
        // Synthesised zero response; the accelerator side is ignored.
        bus.req_resp_valid[owner_q] = 1'b1;
        bus.req_resp_rd             = cmd_q.rd;
      end else begin
`endif
        bus.req_resp_valid[owner_q] = bus.acc_resp_valid;
        bus.acc_resp_ready          = bus.req_resp_ready[owner_q];
        bus.req_resp_rd             = bus.acc_resp_rd;
        bus.req_resp_data           = bus.acc_resp_data;
`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
      end
`endif
    end
  end

  assign resp_fire = |(bus.req_resp_valid & bus.req_resp_ready);

  // Control FSM with registered command buffer, valid and busy outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      owner_q         <= '0;
      last_grant_q    <= IDX_W'(NUM_REQ - 1);
      cmd_q           <= '0;
      acc_cmd_valid_q <= 1'b0;
      busy_q          <= '0;
`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
      timer_q         <= '0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            cmd_q           <= cmd_sel;
            owner_q         <= grant_idx;
            last_grant_q    <= grant_idx;
            busy_q          <= grant;
            acc_cmd_valid_q <= 1'b1;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          if (bus.acc_cmd_ready) begin
            acc_cmd_valid_q <= 1'b0;
            if (cmd_q.xd) begin
              state_q <= StWaitResp;
`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
              timer_q <= '0;
`endif
            end else begin
              state_q <= StIdle;
              busy_q  <= '0;
            end
          end
        end
        StWaitResp: begin
          if (resp_fire) begin
            state_q <= StIdle;
            busy_q  <= '0;
          end
`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
          else if (!timer_expired) begin
            timer_q <= timer_q + 1'b1;
          end
          if (timer_expired) begin
            timeout_q <= 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rocc_share_arbiter.sv
// Self-checking bench for rocc_share_arbiter: table of single transactions plus
// hand-written round-robin, backpressure, stall, reset and (optionally) timeout sequences.
module tb_rocc_share_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned XW   = 64;
  localparam int unsigned TO   = 16;

  typedef struct packed {
    logic [6:0]  funct;
    logic [4:0]  rd;
    logic        xd;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } exp_cmd_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_resp_t;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] xd;
    int         grant;
  } vec_t;

  logic clock;
  logic reset;

  int checks   = 0;
  int failures = 0;

  exp_cmd_t  cmd_sb[$];
  exp_resp_t resp_sb[$];
  int        rr_sb[$];
  vec_t      vecs[7];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  rocc_share_arbiter_if #(.NUM_REQ(NREQ), .XLEN(XW)) bus ();

  rocc_share_arbiter #(
    .NUM_REQ        (NREQ),
    .XLEN           (XW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got nothing expected an entry", name);
  endtask

  function automatic logic [1:0] onehot(input int g);
    logic [1:0] r;
    r = 2'b00;
    r[g] = 1'b1;
    return r;
  endfunction

  function automatic exp_cmd_t mk_cmd(input int i, input int k, input logic xd);
    exp_cmd_t c;
    c.funct = 7'(3 + 2 * k + i);
    c.rd    = 5'(10 + k + i);
    c.xd    = xd;
    c.rs1   = 64'(5 + 16 * k + i) | (64'(k) << 40);
    c.rs2   = 64'(7 + 16 * k + i);
    return c;
  endfunction

  task automatic drive_req(input int i, input exp_cmd_t c);
    bus.req_cmd_funct[7*i +: 7]  = c.funct;
    bus.req_cmd_rd[5*i +: 5]     = c.rd;
    bus.req_cmd_xd[i]            = c.xd;
    bus.req_cmd_rs1[64*i +: 64]  = c.rs1;
    bus.req_cmd_rs2[64*i +: 64]  = c.rs2;
  endtask

  task automatic drive_both(input int k, input logic [1:0] xd);
    for (int i = 0; i < 2; i++) drive_req(i, mk_cmd(i, k, xd[i]));
  endtask

  function automatic exp_cmd_t acc_fields();
    exp_cmd_t a;
    a.funct = bus.acc_cmd_funct;
    a.rd    = bus.acc_cmd_rd;
    a.xd    = bus.acc_cmd_xd;
    a.rs1   = bus.acc_cmd_rs1;
    a.rs2   = bus.acc_cmd_rs2;
    return a;
  endfunction

  // Accelerator model: accept the presented command and compare it to the scoreboard.
  task automatic accept_cmd();
    exp_cmd_t e;
    exp_resp_t r;
    check("acc_cmd_valid", bus.acc_cmd_valid, 1'b1);
    if (cmd_sb.size() == 0) begin
      fail_now("cmd_scoreboard");
    end else begin
      e = cmd_sb.pop_front();
      check("acc_cmd_fields", acc_fields(), e);
      if (e.xd) begin
        r.rd   = e.rd;
        r.data = e.rs1 + e.rs2;
        resp_sb.push_back(r);
      end
    end
  endtask

  // Accelerator returns the next expected response; owner is always ready.
  task automatic deliver_resp(input int owner);
    exp_resp_t r;
    if (resp_sb.size() == 0) begin
      fail_now("resp_scoreboard");
    end else begin
      r = resp_sb.pop_front();
      bus.acc_resp_valid = 1'b1;
      bus.acc_resp_rd    = r.rd;
      bus.acc_resp_data  = r.data;
      bus.req_resp_ready = 2'b11;
      #1;
      check("resp_valid", bus.req_resp_valid, onehot(owner));
      check("resp_data", bus.req_resp_data, r.data);
      check("resp_rd", bus.req_resp_rd, r.rd);
      check("acc_resp_ready", bus.acc_resp_ready, 1'b1);
      @(negedge clock);
      bus.acc_resp_valid = 1'b0;
      bus.req_resp_ready = 2'b00;
      #1;
      check("busy_after_resp", bus.req_busy, 2'b00);
      check("resp_valid_clear", bus.req_resp_valid, 2'b00);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    exp_cmd_t  c;
    exp_resp_t r;
    int        g;
    logic      seen;

    vecs[0] = '{valid: 2'b01, xd: 2'b11, grant: 0};
    vecs[1] = '{valid: 2'b11, xd: 2'b00, grant: 1};
    vecs[2] = '{valid: 2'b11, xd: 2'b11, grant: 0};
    vecs[3] = '{valid: 2'b10, xd: 2'b10, grant: 1};
    vecs[4] = '{valid: 2'b10, xd: 2'b00, grant: 1};
    vecs[5] = '{valid: 2'b11, xd: 2'b01, grant: 0};
    vecs[6] = '{valid: 2'b11, xd: 2'b10, grant: 1};

    bus.req_cmd_valid  = '0;
    bus.req_cmd_funct  = '0;
    bus.req_cmd_rd     = '0;
    bus.req_cmd_xd     = '0;
    bus.req_cmd_rs1    = '0;
    bus.req_cmd_rs2    = '0;
    bus.req_resp_ready = '0;
    bus.acc_cmd_ready  = 1'b0;
    bus.acc_resp_valid = 1'b0;
    bus.acc_resp_rd    = '0;
    bus.acc_resp_data  = '0;
    reset = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_cmd_ready", bus.req_cmd_ready, 2'b00);
    check("rst_acc_cmd_valid", bus.acc_cmd_valid, 1'b0);
    check("rst_busy", bus.req_busy, 2'b00);
    check("rst_resp_valid", bus.req_resp_valid, 2'b00);
    check("rst_acc_resp_ready", bus.acc_resp_ready, 1'b0);
    check("rst_cmd_buffer", acc_fields(), '0);
`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
    check("rst_acc_timeout", bus.acc_timeout, 1'b0);
`endif
    reset = 1'b1;

    // Table-driven single transactions
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      drive_both(k, vecs[k].xd);
      bus.req_cmd_valid = vecs[k].valid;
      #1;
      check("grant", bus.req_cmd_ready, onehot(vecs[k].grant));
      check("no_same_cycle_cmd", bus.acc_cmd_valid, 1'b0);
      cmd_sb.push_back(mk_cmd(vecs[k].grant, k, vecs[k].xd[vecs[k].grant]));
      @(negedge clock);
      bus.req_cmd_valid = '0;
      bus.acc_cmd_ready = 1'b1;
      #1;
      check("busy_issue", bus.req_busy, onehot(vecs[k].grant));
      check("ready_zero_issue", bus.req_cmd_ready, 2'b00);
      accept_cmd();
      @(negedge clock);
      bus.acc_cmd_ready = 1'b0;
      if (vecs[k].xd[vecs[k].grant]) begin
        deliver_resp(vecs[k].grant);
      end else begin
        #1;
        check("busy_after_cmd", bus.req_busy, 2'b00);
      end
    end

    // Both requesters valid continuously, xd=0: grants must alternate 0,1,0,1
    rr_sb.push_back(0);
    rr_sb.push_back(1);
    rr_sb.push_back(0);
    rr_sb.push_back(1);
    @(negedge clock);
    drive_both(7, 2'b00);
    bus.req_cmd_valid = 2'b11;
    bus.acc_cmd_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (bus.req_cmd_ready != 2'b00) begin
        if (rr_sb.size() == 0) begin
          fail_now("rr_extra_grant");
        end else begin
          g = rr_sb.pop_front();
          check("rr_grant", bus.req_cmd_ready, onehot(g));
        end
      end
      @(negedge clock);
    end
    bus.req_cmd_valid = 2'b00;
    bus.acc_cmd_ready = 1'b0;
    check("rr_grant_count", 32'(rr_sb.size()), 32'd0);

    // Response backpressure on requester 1
    drive_both(8, 2'b10);
    bus.req_cmd_valid = 2'b10;
    #1;
    check("bp_grant", bus.req_cmd_ready, 2'b10);
    cmd_sb.push_back(mk_cmd(1, 8, 1'b1));
    @(negedge clock);
    bus.req_cmd_valid = 2'b00;
    bus.acc_cmd_ready = 1'b1;
    #1;
    accept_cmd();
    @(negedge clock);
    bus.acc_cmd_ready = 1'b0;
    if (resp_sb.size() == 0) begin
      fail_now("bp_resp_scoreboard");
      r = '0;
    end else begin
      r = resp_sb.pop_front();
    end
    bus.acc_resp_valid = 1'b1;
    bus.acc_resp_rd    = r.rd;
    bus.acc_resp_data  = r.data;
    bus.req_resp_ready = 2'b00;
    drive_req(0, mk_cmd(0, 9, 1'b0));
    bus.req_cmd_valid = 2'b01;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      check("bp_acc_resp_ready", bus.acc_resp_ready, 1'b0);
      check("bp_resp_valid", bus.req_resp_valid, 2'b10);
      check("bp_resp_data", bus.req_resp_data, r.data);
      check("bp_no_grant", bus.req_cmd_ready, 2'b00);
      @(negedge clock);
    end
    bus.req_resp_ready = 2'b10;
    #1;
    check("bp_release", bus.acc_resp_ready, 1'b1);
    cmd_sb.push_back(mk_cmd(0, 9, 1'b0));
    @(negedge clock);
    bus.acc_resp_valid = 1'b0;
    bus.req_resp_ready = 2'b00;
    #1;
    check("bp_next_grant", bus.req_cmd_ready, 2'b01);

    // Accelerator stall for 4 cycles in issue
    @(negedge clock);
    drive_req(1, mk_cmd(1, 10, 1'b1));
    bus.req_cmd_valid = 2'b10;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      check("stall_valid", bus.acc_cmd_valid, 1'b1);
      if (cmd_sb.size() != 0) check("stall_fields", acc_fields(), cmd_sb[0]);
      check("stall_no_ready", bus.req_cmd_ready, 2'b00);
      check("stall_busy", bus.req_busy, 2'b01);
      @(negedge clock);
    end
    bus.acc_cmd_ready = 1'b1;
    #1;
    accept_cmd();
    @(negedge clock);
    bus.acc_cmd_ready = 1'b0;
    #1;
    check("stall_next_grant", bus.req_cmd_ready, 2'b10);
    cmd_sb.push_back(mk_cmd(1, 10, 1'b1));
    @(negedge clock);
    bus.req_cmd_valid = 2'b00;
    bus.acc_cmd_ready = 1'b1;
    #1;
    accept_cmd();
    @(negedge clock);
    bus.acc_cmd_ready = 1'b0;

    // Asynchronous reset while waiting for requester 1's response
    drive_both(11, 2'b00);
    bus.req_cmd_valid  = 2'b11;
    bus.acc_resp_valid = 1'b1;
    bus.req_resp_ready = 2'b00;
    #1;
    check("pre_rst_resp_valid", bus.req_resp_valid, 2'b10);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", bus.req_busy, 2'b00);
    check("arst_resp_valid", bus.req_resp_valid, 2'b00);
    check("arst_acc_resp_ready", bus.acc_resp_ready, 1'b0);
    check("arst_acc_cmd_valid", bus.acc_cmd_valid, 1'b0);
    check("arst_cmd_ready", bus.req_cmd_ready, 2'b00);
    check("arst_cmd_buffer", acc_fields(), '0);
    resp_sb.delete();
    @(negedge clock);
    bus.acc_resp_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("post_rst_grant", bus.req_cmd_ready, 2'b01);
    cmd_sb.push_back(mk_cmd(0, 11, 1'b0));
    @(negedge clock);
    bus.req_cmd_valid = 2'b00;
    bus.acc_cmd_ready = 1'b1;
    #1;
    accept_cmd();
    @(negedge clock);
    bus.acc_cmd_ready = 1'b0;
    #1;
    check("post_rst_idle_busy", bus.req_busy, 2'b00);

`ifdef ROCC_SHARE_ARB_TIMEOUT_EN
    // No response from the accelerator: watchdog answers the owner with zero data
    @(negedge clock);
    drive_req(0, mk_cmd(0, 12, 1'b1));
    bus.req_cmd_valid = 2'b01;
    #1;
    check("to_grant", bus.req_cmd_ready, 2'b01);
    cmd_sb.push_back(mk_cmd(0, 12, 1'b1));
    @(negedge clock);
    bus.req_cmd_valid = 2'b00;
    bus.acc_cmd_ready = 1'b1;
    #1;
    accept_cmd();
    resp_sb.delete();
    @(negedge clock);
    bus.acc_cmd_ready  = 1'b0;
    bus.req_resp_ready = 2'b01;
    seen = 1'b0;
    for (int cyc = 0; cyc < TO + 8 && !seen; cyc++) begin
      #1;
      if (bus.req_resp_valid != 2'b00) begin
        seen = 1'b1;
        c = mk_cmd(0, 12, 1'b1);
        check("to_resp_valid", bus.req_resp_valid, 2'b01);
        check("to_resp_data", bus.req_resp_data, 64'd0);
        check("to_resp_rd", bus.req_resp_rd, c.rd);
      end
      @(negedge clock);
    end
    check("to_resp_seen", seen, 1'b1);
    bus.req_resp_ready = 2'b00;
    repeat (3) @(negedge clock);
    #1;
    check("to_sticky", bus.acc_timeout, 1'b1);
    check("to_busy_clear", bus.req_busy, 2'b00);
`endif

    check("cmd_sb_drained", 32'(cmd_sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
